// File: rtl/sfu_order2_eval.sv
// Second-order polynomial evaluator: y = C0 + C1*xl + C2*xl^2, producing a
// 27-bit unsigned fraction with clamp flags. Three register stages with valid/ready.
module sfu_order2_eval #(
   parameter int XL_W  = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XL_W-1:0]  xl,
   input  logic [27:0]      c0,
   input  logic [19:0]      c1,
   input  logic [13:0]      c2,
   input  logic             sign_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [26:0]      y,
   output logic             y_zero,
   output logic             sat_hi,
   output logic             sat_lo,
   output logic             sign_out,
   output logic [TAG_W-1:0] tag_out
);

   localparam int SQ_W = 2 * XL_W;
   localparam int P1_W = 20 + XL_W + 1;
   localparam int P2_W = 14 + XL_W + 1;

   // ---------------- handshake ----------------
   logic r_v1, r_v2, r_v3;
   logic w_ld1, w_ld2, w_ld3;

   assign w_ld3     = !r_v3 || out_ready;
   assign w_ld2     = !r_v2 || w_ld3;
   assign w_ld1     = !r_v1 || w_ld2;
   assign in_ready  = w_ld1;
   assign out_valid = r_v3;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else begin
         if (w_ld1) r_v1 <= in_valid;
         if (w_ld2) r_v2 <= r_v1;
         if (w_ld3) r_v3 <= r_v2;
      end
   end

   // ---------------- S1: capture + square ----------------
   logic [XL_W-1:0]  r1_xl;
   logic [27:0]      r1_c0;
   logic [19:0]      r1_c1;
   logic [13:0]      r1_c2;
   logic [SQ_W-1:0]  r1_sq;
   logic             r1_sign;
   logic [TAG_W-1:0] r1_tag;

   // Data only moves behind a valid token, so unreset regs never reach outputs as X.
   always_ff @(posedge clk) begin
      if (w_ld1 && in_valid) begin
         r1_xl   <= xl;
         r1_c0   <= c0;
         r1_c1   <= c1;
         r1_c2   <= c2;
         r1_sq   <= {{XL_W{1'b0}}, xl} * {{XL_W{1'b0}}, xl};
         r1_sign <= sign_in;
         r1_tag  <= tag_in;
      end
   end

   // ---------------- S2: products aligned to 2^-28 ----------------
   logic signed [P1_W-1:0] w_p1_full;
   logic signed [P2_W-1:0] w_p2_full;
   logic        [XL_W-1:0] w_sq_hi;

   assign w_sq_hi   = XL_W'(r1_sq >> XL_W);
   assign w_p1_full = $signed({{(P1_W-20){r1_c1[19]}}, r1_c1})
                    * $signed({{(P1_W-XL_W){1'b0}}, r1_xl});
   assign w_p2_full = $signed({{(P2_W-14){r1_c2[13]}}, r1_c2})
                    * $signed({{(P2_W-XL_W){1'b0}}, w_sq_hi});

   logic        [27:0]      r2_c0;
   logic signed [31:0]      r2_p1;
   logic signed [31:0]      r2_p2;
   logic                    r2_sign;
   logic        [TAG_W-1:0] r2_tag;

   always_ff @(posedge clk) begin
      if (w_ld2 && r_v1) begin
         r2_c0   <= r1_c0;
         r2_p1   <= 32'(w_p1_full >>> (XL_W - 8));
         r2_p2   <= 32'(w_p2_full >>> (XL_W - 14));
         r2_sign <= r1_sign;
         r2_tag  <= r1_tag;
      end
   end

   // ---------------- S3: sum and clamp ----------------
   logic signed [31:0] w_s;
   logic        [26:0] w_y;
   logic               w_hi, w_lo;

   assign w_s = $signed({4'b0000, r2_c0}) + r2_p1 + r2_p2;

   always_comb begin
      w_y  = '0;
      w_hi = 1'b0;
      w_lo = 1'b0;
      if (w_s < 0) begin
         w_lo = 1'b1;
      end else if (w_s > 32'sd268435455) begin
         w_hi = 1'b1;
         w_y  = '1;
      end else begin
         w_y  = w_s[27:1];
      end
   end

   logic [26:0]      r3_y;
   logic             r3_zero, r3_hi, r3_lo, r3_sign;
   logic [TAG_W-1:0] r3_tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         r3_y    <= '0;
         r3_zero <= 1'b1;
         r3_hi   <= 1'b0;
         r3_lo   <= 1'b0;
         r3_sign <= 1'b0;
         r3_tag  <= '0;
      end else if (w_ld3 && r_v2) begin
         r3_y    <= w_y;
         r3_zero <= (w_y == '0);
         r3_hi   <= w_hi;
         r3_lo   <= w_lo;
         r3_sign <= r2_sign;
         r3_tag  <= r2_tag;
      end
   end

   assign y        = r3_y;
   assign y_zero   = r3_zero;
   assign sat_hi   = r3_hi;
   assign sat_lo   = r3_lo;
   assign sign_out = r3_sign;
   assign tag_out  = r3_tag;

endmodule

// File: doc/sfu_order2_eval.md
Name: sfu_order2_eval

Overview:
- Pipelined second-order polynomial evaluator for the SFU order-2 datapath.
- Computes y = C0 + C1·xl + C2·xl² from table coefficients and the low operand bits.
- Produces the 27-bit unsigned fraction (weights 2^-1..2^-27) consumed directly by the leading-one detector/normaliser stage.
- Three register stages with valid/ready backpressure; sign and tag sideband travel alongside the data.

Parameters:
- XL_W, 16, width of the low operand xl, unsigned, value xl/2^16.
- TAG_W, 4, width of the opaque sideband tag carried with each operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request this cycle.
- xl  in  XL_W  low operand, unsigned fraction.
- c0  in  28  unsigned coefficient, value c0/2^28.
- c1  in  20  signed two's-complement coefficient, value c1/2^20.
- c2  in  14  signed two's-complement coefficient, value c2/2^14.
- sign_in  in  1  result sign, passed through unchanged.
- tag_in  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- y  out  27  result fraction, bit 26 weight 2^-1, bit 0 weight 2^-27.
- y_zero  out  1  y == 0 (downstream normaliser emits exponent 0).
- sat_hi  out  1  result was clamped to its maximum.
- sat_lo  out  1  result was negative and clamped to 0.
- sign_out  out  1  sign_in delayed with its data.
- tag_out  out  TAG_W  tag_in delayed with its data.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage S1 (capture): register xl, c0, c1, c2, sign, tag, and sq = xl·xl (32-bit unsigned).
- Stage S2 (products):
  - p1 = c1 · xl, signed 37-bit, arithmetic shift right 8 (units 2^-28).
  - sq16 = sq[31:16].
  - p2 = c2 · sq16, signed 31-bit, arithmetic shift right 2 (units 2^-28).
  - Shifted-out bits are truncated; no rounding.
- Stage S3 (sum/clamp):
  - s = c0 + p1 + p2 in 32-bit signed; no intermediate overflow is possible.
  - If s < 0: y = 0, sat_lo = 1.
  - Else if s > 2^28-1: y = 27'h7FFFFFF, sat_hi = 1.
  - Otherwise y = s[27:1], with the LSB truncated.
  - y_zero = (y == 0), including the clamped-low case.
  - sat_hi and sat_lo are never both 1.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Backpressure:
  - Each stage k holds valid v_k.
  - Stage k loads when !v_k || stage k+1 loads; the stage after S3 is the output transfer.
  - in_ready = !v1 || S2 loads, purely combinational from the valids and out_ready.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Stall rules:
  - While out_valid && !out_ready, every output (y, flags, sign_out, tag_out) holds stable.
  - No operation is dropped, duplicated or reordered.
  - With 3 ops resident and out_ready low, in_ready = 0.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both honoured.
- Reset:
  - On rst = 1 at a clock edge, all valids clear and out_valid = 0.
  - y = 0, y_zero = 1, sat_hi = sat_lo = 0, sign_out = 0, tag_out = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight ops; none emerge afterwards.
- Data registers other than the outputs need no reset, but must not produce X on any output while the corresponding valid is 0 after reset.

Test Plan:
1. c0 = 2^27, c1 = 0, c2 = 0, xl = 16'h1234, out_ready = 1 → 3 cycles later y = 27'h4000000, y_zero = 0, no saturation flags.
2. c0 = 0, c1 = 2^19, c2 = 0, xl = 16'h8000 → y = 27'h2000000. Next case: c1 = 0, c2 = 2^13, xl = 16'h8000 → y = 27'h1000000.
3. c0 = 0, c1 = -2^19, c2 = 0, xl = 16'h8000 → y = 0, sat_lo = 1, y_zero = 1. Then c0 = 28'hFFFFFFF, c1 = 20'h7FFFF, xl = 16'hFFFF → y = 27'h7FFFFFF, sat_hi = 1.
4. Backpressure: stream 5 ops with distinct tags 0..4 while out_ready = 0 → in_ready drops after 3 accepts and outputs hold stable. Raise out_ready → tags 0..4 emerge in order, one per cycle, with correct y values.
5. Random valid/ready toggling, 10k ops, checked against a scoreboard model of the exact truncation/clamp rules → zero mismatches, no loss or reorder.
6. Assert rst for 1 cycle with 2 ops in flight → out_valid = 0 and in_ready = 1 the next cycle; neither op appears later; an op issued right after reset emerges with 3-cycle latency.
